// File: rtl/scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment display controller:
// hex segment table, idle levels for the digit enables and segment bus.
package scan_display_pkg;

    localparam int DP_BIT = 7;

    localparam logic [7:0] COM_OFF = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Segments g..a, active-high, for nibble values 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_segments(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-segment decoder with decimal point merged in.
module seg_hex_decoder
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern         = {1'b0, hex_segments(nibble)};
        pattern[DP_BIT] = dp;
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed hex display driver: slot scanning, PWM brightness,
// leading-zero suppression and per-digit blinking, all outputs registered.
module scan_display_ctrl
    import scan_display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dot_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     com,
    output logic [7:0]            arraydata,
    output logic                  frame_start
);

    localparam int CW   = $clog2(PRESCALE);
    localparam int SW   = $clog2(DIGITS);
    localparam int STEP = PRESCALE / 16;
    localparam int DW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0]     CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [DW-1:0]     STEP_LAST  = DW'(STEP - 1);
    localparam logic [SW-1:0]     SLOT_LAST  = SW'(DIGITS - 1);
    localparam logic [FW-1:0]     FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] COM_IDLE   = COM_OFF[DIGITS-1:0];

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("scan_display_ctrl: DIGITS must be in 2..8");
    end
    if (PRESCALE < 16 || (PRESCALE % 16) != 0) begin : g_bad_prescale
        $error("scan_display_ctrl: PRESCALE must be >= 16 and a multiple of 16");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("scan_display_ctrl: BLINK_FRAMES must be >= 1");
    end

    logic [CW-1:0]     cnt;
    logic [DW-1:0]     pwm_div;
    logic [3:0]        pwm_phase;
    logic [SW-1:0]     slot;
    logic [FW-1:0]     frame_cnt;
    logic              blink_phase;
    logic              running;
    logic [DIGITS-1:0] com_pattern;

    logic              tick;
    logic [SW-1:0]     next_slot;
    logic [SW-1:0]     pos;
    logic [3:0]        nibble;
    logic              lead_zero;
    logic              frame_done;
    logic [FW-1:0]     frame_next;
    logic              blink_next;
    logic              blanked;
    logic [DIGITS-1:0] pattern_next;
    logic [7:0]        seg_pattern;

    assign tick = (cnt == CNT_LAST);

    // Everything below describes the slot that becomes visible after the tick.
    always_comb begin
        // NOTE: every combinational output is given a value before any branch, so no latch can be inferred.
        next_slot  = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        pos        = SLOT_LAST - next_slot;
        nibble     = 4'(data >> {pos, 2'b00});

        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= int'(next_slot) && data[4*(DIGITS-1-i) +: 4] != 4'h0) begin
                lead_zero = 1'b0;
            end
        end

        // The very first tick after reset opens frame 0; it does not close a frame.
        frame_done = running && (slot == SLOT_LAST);
        frame_next = frame_cnt;
        blink_next = blink_phase;
        if (frame_done) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_next = '0;
                blink_next = ~blink_phase;
            end else begin
                frame_next = frame_cnt + 1'b1;
            end
        end

        blanked = (blank_lz && lead_zero && next_slot != SLOT_LAST)
               || (blink_next && blink_mask[pos]);
        pattern_next = blanked ? COM_IDLE : ~(DIGITS'(1) << pos);
    end

    seg_hex_decoder u_decoder (
        .nibble  (nibble),
        .dp      (dot_mask[pos]),
        .pattern (seg_pattern)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            pwm_div     <= '0;
            pwm_phase   <= '0;
            slot        <= SLOT_LAST;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            running     <= 1'b0;
            com_pattern <= COM_IDLE;
            com         <= COM_IDLE;
            arraydata   <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here read its pre-edge value.
            frame_start <= 1'b0;
            if (tick) begin
                cnt         <= '0;
                pwm_div     <= '0;
                pwm_phase   <= '0;
                slot        <= next_slot;
                running     <= 1'b1;
                frame_cnt   <= frame_next;
                blink_phase <= blink_next;
                com_pattern <= pattern_next;
                com         <= pattern_next;
                arraydata   <= blanked ? SEG_OFF : seg_pattern;
                frame_start <= (next_slot == '0);
            end else begin
                cnt <= cnt + 1'b1;
                // Phase 15 ends exactly on the tick, so the increment never wraps here.
                if (pwm_div == STEP_LAST) begin
                    pwm_div   <= '0;
                    pwm_phase <= pwm_phase + 4'd1;
                    com       <= (pwm_phase + 4'd1 <= bright) ? com_pattern : COM_IDLE;
                end else begin
                    pwm_div <= pwm_div + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl: directed scenarios plus random
// traffic, all compared cycle by cycle against a time-based reference model.
module tb_scan_display_ctrl;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 16;
    localparam int BLINK_FRAMES = 2;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [15:0] data       = 16'h0000;
    logic [3:0]  dot_mask   = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        blank_lz   = 1'b0;
    logic [3:0]  bright     = 4'hF;
    logic [3:0]  com;
    logic [7:0]  arraydata;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [15:0] snap_data;
    logic [3:0]  snap_dot;
    logic [3:0]  snap_blink;
    logic        snap_lz;

    logic [6:0] hex_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    scan_display_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .dot_mask    (dot_mask),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .bright      (bright),
        .com         (com),
        .arraydata   (arraydata),
        .frame_start (frame_start)
    );

    // Expected outputs after the n-th rising edge since reset release.
    function automatic void model(output logic [3:0] e_com, output logic [7:0] e_seg,
                                  output logic e_fs);
        int s, k, f;
        logic [3:0] nib;
        bit all_zero, blank;
        e_com = 4'hF;
        e_seg = 8'h00;
        e_fs  = 1'b0;
        if (n < PRESCALE) return;
        s = n / PRESCALE - 1;
        k = s % DIGITS;
        f = s / DIGITS;
        e_fs = (n % (PRESCALE * DIGITS)) == PRESCALE;
        nib = snap_data[4*(DIGITS-1-k) +: 4];
        all_zero = 1'b1;
        for (int i = 0; i <= k; i++)
            if (snap_data[4*(DIGITS-1-i) +: 4] != 4'h0) all_zero = 1'b0;
        blank = (snap_lz && all_zero && k != DIGITS-1)
             || (((f / BLINK_FRAMES) % 2 == 1) && snap_blink[DIGITS-1-k]);
        if (blank) return;
        e_seg = {snap_dot[DIGITS-1-k], hex_ref[nib]};
        if ((n % PRESCALE) <= int'(bright)) e_com = ~(4'b0001 << (DIGITS-1-k));
    endfunction

    function automatic logic [15:0] rand_data();
        logic [15:0] d;
        for (int i = 0; i < 4; i++)
            d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        return d;
    endfunction

    task automatic run(input int cycles, input bit rnd);
        logic [3:0] e_com;
        logic [7:0] e_seg;
        logic       e_fs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            n++;
            if (n >= PRESCALE && n % PRESCALE == 0) begin
                snap_data  = data;
                snap_dot   = dot_mask;
                snap_blink = blink_mask;
                snap_lz    = blank_lz;
            end
            model(e_com, e_seg, e_fs);
            total++;
            if (com !== e_com) begin
                bad++;
                $display("FAIL com n=%0d got=%b want=%b", n, com, e_com);
            end
            total++;
            if (arraydata !== e_seg) begin
                bad++;
                $display("FAIL arraydata n=%0d got=%h want=%h", n, arraydata, e_seg);
            end
            total++;
            if (frame_start !== e_fs) begin
                bad++;
                $display("FAIL frame_start n=%0d got=%b want=%b", n, frame_start, e_fs);
            end
            if (rnd) begin
                if ($urandom_range(0, 7) == 0) data = rand_data();
                if ($urandom_range(0, 15) == 0) dot_mask = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if (com !== 4'hF || arraydata !== 8'h00 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_immediate got com=%b seg=%h fs=%b want 1111/00/0",
                     com, arraydata, frame_start);
        end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
    endtask

    task automatic expect_out(input string name, input logic [3:0] e_com, input logic [7:0] e_seg);
        total++;
        if (com !== e_com || arraydata !== e_seg) begin
            bad++;
            $display("FAIL %s n=%0d got com=%b seg=%h want com=%b seg=%h",
                     name, n, com, arraydata, e_com, e_seg);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        expect_out("reset_state", 4'hF, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        data = 16'h1234; dot_mask = 4'h0; bright = 4'hF;
        run(15, 0);
        expect_out("idle_before_first_slot", 4'hF, 8'h00);
        run(1, 0);
        expect_out("first_slot_after_reset", 4'b0111, 8'h06);
    endtask

    task automatic test_basic();
        do_reset();
        data = 16'h1234; dot_mask = 4'b0101; bright = 4'hF; blank_lz = 1'b0; blink_mask = 4'h0;
        run(17, 0); expect_out("basic_slot0", 4'b0111, 8'h06);
        run(16, 0); expect_out("basic_slot1", 4'b1011, 8'hDB);
        run(16, 0); expect_out("basic_slot2", 4'b1101, 8'h4F);
        run(16, 0); expect_out("basic_slot3", 4'b1110, 8'hE6);
        run(64, 0);
    endtask

    task automatic test_blank_lz();
        do_reset();
        data = 16'h0040; dot_mask = 4'h0; bright = 4'hF; blank_lz = 1'b1; blink_mask = 4'h0;
        run(17, 0); expect_out("lz_slot0", 4'hF, 8'h00);
        run(16, 0); expect_out("lz_slot1", 4'hF, 8'h00);
        run(16, 0); expect_out("lz_slot2", 4'b1101, 8'h66);
        run(16, 0); expect_out("lz_slot3", 4'b1110, 8'h3F);
        data = 16'h0000;
        run(16, 0); expect_out("lz_zero_slot0", 4'hF, 8'h00);
        run(32, 0); expect_out("lz_zero_slot2", 4'hF, 8'h00);
        run(16, 0); expect_out("lz_zero_slot3", 4'b1110, 8'h3F);
        blank_lz = 1'b0;
    endtask

    task automatic test_pwm();
        int low;
        do_reset();
        data = 16'h1234; dot_mask = 4'h0; bright = 4'd3;
        run(15, 0);
        for (int s = 0; s < DIGITS; s++) begin
            low = 0;
            for (int c = 0; c < PRESCALE; c++) begin
                run(1, 0);
                if (com !== 4'hF) low++;
            end
            total++;
            if (low !== 4) begin
                bad++;
                $display("FAIL pwm_on_cycles slot=%0d got=%0d want=4", s, low);
            end
        end
        bright = 4'hF;
    endtask

    task automatic test_blink();
        do_reset();
        data = 16'h1234; dot_mask = 4'h0; bright = 4'hF; blink_mask = 4'b0001;
        run(65, 0);  expect_out("blink_f0_slot3", 4'b1110, 8'h66);
        run(64, 0);  expect_out("blink_f1_slot3", 4'b1110, 8'h66);
        run(64, 0);  expect_out("blink_f2_slot3", 4'hF, 8'h00);
        run(64, 0);  expect_out("blink_f3_slot3", 4'hF, 8'h00);
        run(64, 0);  expect_out("blink_f4_slot3", 4'b1110, 8'h66);
        run(16, 0);
        blink_mask = 4'h0;
    endtask

    task automatic test_reset_midslot();
        do_reset();
        data = 16'h1234; dot_mask = 4'h0; bright = 4'hF;
        run(53, 0);
        expect_out("pre_reset_slot2", 4'b1101, 8'h4F);
        do_reset();
        run(15, 0);
        expect_out("post_reset_idle", 4'hF, 8'h00);
        run(1, 0);
        expect_out("post_reset_slot0", 4'b0111, 8'h06);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_frame_start got=%b want=1", frame_start);
        end
    endtask

    task automatic test_data_change();
        do_reset();
        data = 16'h1234; dot_mask = 4'h0; bright = 4'hF;
        run(37, 0);
        data = 16'hABCD;
        run(1, 0);  expect_out("change_slot1_hold", 4'b1011, 8'h5B);
        run(9, 0);  expect_out("change_slot1_end", 4'b1011, 8'h5B);
        run(2, 0);  expect_out("change_slot2_new", 4'b1101, 8'h39);
        run(16, 0); expect_out("change_slot3_new", 4'b1110, 8'h5E);
    endtask

    task automatic test_random();
        do_reset();
        data = rand_data();
        run(3000, 1);
        do_reset();
        run(1500, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank_lz();
        test_pwm();
        test_blink();
        test_reset_midslot();
        test_data_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter PRESCALE, default 1024, clk cycles per digit slot (legal: >=16, multiple of 16).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full frames per blink half-period (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data  input  4*DIGITS  hex/BCD nibbles, slot 0 = most significant nibble.
REQ-007 SHALL have port dot_mask  input  DIGITS  decimal point enable, bit aligned with com bit.
REQ-008 SHALL have port blink_mask  input  DIGITS  blink enable, bit aligned with com bit.
REQ-009 SHALL have port blank_lz  input  1  leading-zero suppression enable.
REQ-010 SHALL have port bright  input  4  brightness, on-time (bright+1)/16 of each slot.
REQ-011 SHALL have port com  output  DIGITS  active-low digit enables, at most one low.
REQ-012 SHALL have port arraydata  output  8  segments, active-high, [7]=dp, [6:0]=g..a.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when slot 0 begins.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick = cycle at PRESCALE-1.
REQ-015 On tick, slot SHALL advance k -> k+1, DIGITS-1 -> 0; new com/arraydata SHALL appear the cycle after tick.
REQ-016 Slot k SHALL drive com bit DIGITS-1-k low and decode nibble data[4*(DIGITS-k)-1 -: 4].
REQ-017 data, dot_mask, blink_mask, blank_lz SHALL be sampled only on tick; mid-slot changes SHALL take effect next slot.
REQ-018 Decoder: 0-9 standard, A-F hex (0x77,0x7C,0x39,0x5E,0x79,0x71); dp OR'd as bit 7.
REQ-019 pwm_phase (4 bit) SHALL increment every PRESCALE/16 cycles, reset to 0 at slot start; com active only while pwm_phase <= bright, else all ones; arraydata held.
REQ-020 blank_lz=1: slot k blanked when nibbles of slots 0..k all zero; slot DIGITS-1 never blanked by this rule.
REQ-021 blink_phase SHALL toggle after every BLINK_FRAMES completed frames; while 1, slots with blink_mask set blanked.
REQ-022 Blanked slot: com all ones and arraydata 0x00 for the entire slot.
REQ-023 frame_start SHALL pulse high the cycle slot 0 outputs first appear; frame counter wraps without gap.

Reset
REQ-024 reset low SHALL immediately force com all ones, arraydata 0x00, frame_start 0.
REQ-025 reset SHALL clear prescaler, pwm_phase, frame counter, blink_phase to 0 and slot register to DIGITS-1.
REQ-026 After release, first display SHALL be slot 0, PRESCALE cycles later, with frame_start pulse.

Structure
REQ-027 Shared package scan_display_pkg SHALL hold the 16-entry segment table, COM_OFF/SEG_OFF constants, dp bit index.
REQ-028 One combinational sub-module seg_hex_decoder (nibble, dp -> 8-bit pattern) SHALL be instantiated once.
REQ-029 Parameter legality SHALL be checked at elaboration; illegal values SHALL fail build.

Verification (DIGITS=4, PRESCALE=16, BLINK_FRAMES=2)
REQ-030 data=16'h1234, dot_mask=4'b0101, bright=15 -> com 0111/1011/1101/1110, arraydata 0x06/0xDB/0x4F/0xE6, 16 cycles each.
REQ-031 blank_lz=1, data=16'h0040 -> slots 0,1 com 1111, 0x00; slot 2 0x66; slot 3 0x3F; data=0 -> only slot 3 shows 0x3F.
REQ-032 bright=3 -> com low exactly 4 of 16 cycles per slot (first 4), high otherwise.
REQ-033 blink_mask=4'b0001 -> slot 3 shown frames 0-1, blank frames 2-3; frame_start every 64 cycles.
REQ-034 reset low mid-slot 2 -> com 1111, arraydata 0x00 same cycle; after release com 0111 after 16 cycles.
REQ-035 data changed mid-slot 1 -> slot 1 output unchanged until boundary; slot 2 reflects new value.
